// File: rtl/jtag_dmi_intc.sv
// jtag_dmi_intc: bridges a JTAG-clocked request/response level handshake onto
// a DMI valid/ready request and response channel in the core clock domain.
// The JTAG-side levels are synchronized. A rising edge of the synchronized
// request-valid level starts one transaction.
module jtag_dmi_intc #(
  parameter int DMI_ADDR_WIDTH = 7,
  parameter int DMI_DATA_WIDTH = 32,
  parameter int DMI_OP_WIDTH   = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                                             clk,
  input  logic                                             dev_rst_n,
  input  logic                                             jreq_vld,
  input  logic [DMI_ADDR_WIDTH+DMI_DATA_WIDTH+DMI_OP_WIDTH-1:0] jreq_data,
  output logic                                             jreq_rdy,
  output logic                                             jresp_vld,
  output logic [DMI_DATA_WIDTH+DMI_OP_WIDTH-1:0]           jresp_data,
  input  logic                                             jresp_rdy,
  output logic                                             dmi_req_valid,
  input  logic                                             dmi_req_ready,
  output logic [DMI_ADDR_WIDTH-1:0]                        dmi_req_addr,
  output logic [DMI_DATA_WIDTH-1:0]                        dmi_req_data,
  output logic [DMI_OP_WIDTH-1:0]                          dmi_req_op,
  input  logic                                             dmi_resp_valid,
  output logic                                             dmi_resp_ready,
  input  logic [DMI_DATA_WIDTH-1:0]                        dmi_resp_data,
  input  logic [DMI_OP_WIDTH-1:0]                          dmi_resp_resp
);

  localparam int REQ_W  = DMI_ADDR_WIDTH + DMI_DATA_WIDTH + DMI_OP_WIDTH;
  localparam int RESP_W = DMI_DATA_WIDTH + DMI_OP_WIDTH;

  // Op codes on the request side and the "failed" response code
  localparam logic [DMI_OP_WIDTH-1:0] OP_NOP      = DMI_OP_WIDTH'(0);
  localparam logic [DMI_OP_WIDTH-1:0] OP_READ     = DMI_OP_WIDTH'(1);
  localparam logic [DMI_OP_WIDTH-1:0] OP_WRITE    = DMI_OP_WIDTH'(2);
  localparam logic [DMI_OP_WIDTH-1:0] RESP_OK     = DMI_OP_WIDTH'(0);
  localparam logic [DMI_OP_WIDTH-1:0] RESP_FAILED = DMI_OP_WIDTH'(2);

  // Last WAIT count value; the edge that sees it is the TIMEOUT_CYCLES-th clock in WAIT
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  state_e                      state_r;
  logic                        jreq_vld_meta_r;
  logic                        jreq_vld_sync_r;
  logic                        jreq_vld_prev_r;
  logic                        jresp_rdy_meta_r;
  logic                        jresp_rdy_sync_r;
  logic [7:0]                  wait_cnt_r;

  logic                        jreq_rdy_r;
  logic                        jresp_vld_r;
  logic [RESP_W-1:0]           jresp_data_r;
  logic                        dmi_req_valid_r;
  logic [DMI_ADDR_WIDTH-1:0]   dmi_req_addr_r;
  logic [DMI_DATA_WIDTH-1:0]   dmi_req_data_r;
  logic [DMI_OP_WIDTH-1:0]     dmi_req_op_r;
  logic                        dmi_resp_ready_r;

  logic                        req_event_s;
  logic [DMI_ADDR_WIDTH-1:0]   req_addr_s;
  logic [DMI_DATA_WIDTH-1:0]   req_data_s;
  logic [DMI_OP_WIDTH-1:0]     req_op_s;

  // Fields of the incoming request word {addr, data, op}
  assign req_addr_s = jreq_data[REQ_W-1 -: DMI_ADDR_WIDTH];
  assign req_data_s = jreq_data[RESP_W-1 -: DMI_DATA_WIDTH];
  assign req_op_s   = jreq_data[DMI_OP_WIDTH-1:0];

  // New request only on a rising edge of the synchronized valid level
  assign req_event_s = jreq_vld_sync_r & ~jreq_vld_prev_r;

  // Two-flop synchronizers for the JTAG levels plus the edge-detect copy
  always_ff @(posedge clk or negedge dev_rst_n) begin
    if (!dev_rst_n) begin
      jreq_vld_meta_r  <= 1'b0;
      jreq_vld_sync_r  <= 1'b0;
      jreq_vld_prev_r  <= 1'b0;
      jresp_rdy_meta_r <= 1'b0;
      jresp_rdy_sync_r <= 1'b0;
    end else begin
      jreq_vld_meta_r  <= jreq_vld;
      jreq_vld_sync_r  <= jreq_vld_meta_r;
      jreq_vld_prev_r  <= jreq_vld_sync_r;
      jresp_rdy_meta_r <= jresp_rdy;
      jresp_rdy_sync_r <= jresp_rdy_meta_r;
    end
  end

  // Transaction FSM; every handshake output is registered alongside the state
  always_ff @(posedge clk or negedge dev_rst_n) begin
    if (!dev_rst_n) begin
      state_r          <= ST_IDLE;
      wait_cnt_r       <= 8'd0;
      jreq_rdy_r       <= 1'b1;
      jresp_vld_r      <= 1'b0;
      jresp_data_r     <= {RESP_W{1'b0}};
      dmi_req_valid_r  <= 1'b0;
      dmi_req_addr_r   <= {DMI_ADDR_WIDTH{1'b0}};
      dmi_req_data_r   <= {DMI_DATA_WIDTH{1'b0}};
      dmi_req_op_r     <= {DMI_OP_WIDTH{1'b0}};
      dmi_resp_ready_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_event_s) begin
            dmi_req_addr_r <= req_addr_s;
            dmi_req_data_r <= req_data_s;
            dmi_req_op_r   <= req_op_s;
            jreq_rdy_r     <= 1'b0;
            case (req_op_s)
              OP_READ, OP_WRITE: begin
                state_r         <= ST_REQ;
                dmi_req_valid_r <= 1'b1;
              end
              OP_NOP: begin
                // A no-op completes locally with a clean, zero response
                state_r      <= ST_RESP;
                jresp_vld_r  <= 1'b1;
                jresp_data_r <= {{DMI_DATA_WIDTH{1'b0}}, RESP_OK};
              end
              default: begin
                // Reserved op: answered locally as a failure, never sent to DMI
                state_r      <= ST_RESP;
                jresp_vld_r  <= 1'b1;
                jresp_data_r <= {{DMI_DATA_WIDTH{1'b0}}, RESP_FAILED};
              end
            endcase
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_REQ: begin
          // Request is held until accepted; there is deliberately no timeout here
          if (dmi_req_ready) begin
            state_r          <= ST_WAIT;
            dmi_req_valid_r  <= 1'b0;
            dmi_resp_ready_r <= 1'b1;
            wait_cnt_r       <= 8'd0;
          end else begin
            state_r <= ST_REQ;
          end
        end
        ST_WAIT: begin
          // A response arriving on the timeout edge wins over the timeout
          if (dmi_resp_valid) begin
            state_r          <= ST_RESP;
            dmi_resp_ready_r <= 1'b0;
            jresp_vld_r      <= 1'b1;
            jresp_data_r     <= {dmi_resp_data, dmi_resp_resp};
          end else if (wait_cnt_r == CNT_LAST) begin
            state_r          <= ST_RESP;
            dmi_resp_ready_r <= 1'b0;
            jresp_vld_r      <= 1'b1;
            jresp_data_r     <= {{DMI_DATA_WIDTH{1'b0}}, RESP_FAILED};
          end else begin
            wait_cnt_r <= wait_cnt_r + 8'd1;
          end
        end
        ST_RESP: begin
          // JTAG side must drop its request and be ready before we go idle
          if (!jreq_vld_sync_r && jresp_rdy_sync_r) begin
            state_r     <= ST_IDLE;
            jresp_vld_r <= 1'b0;
            jreq_rdy_r  <= 1'b1;
          end else begin
            state_r <= ST_RESP;
          end
        end
        default: begin
          state_r          <= ST_IDLE;
          jreq_rdy_r       <= 1'b1;
          jresp_vld_r      <= 1'b0;
          dmi_req_valid_r  <= 1'b0;
          dmi_resp_ready_r <= 1'b0;
        end
      endcase
    end
  end

  assign jreq_rdy       = jreq_rdy_r;
  assign jresp_vld      = jresp_vld_r;
  assign jresp_data     = jresp_data_r;
  assign dmi_req_valid  = dmi_req_valid_r;
  assign dmi_req_addr   = dmi_req_addr_r;
  assign dmi_req_data   = dmi_req_data_r;
  assign dmi_req_op     = dmi_req_op_r;
  assign dmi_resp_ready = dmi_resp_ready_r;

endmodule

// File: tb/tb_jtag_dmi_intc.sv
// Directed bench for jtag_dmi_intc: read, write with backpressure, local
// no-op/reserved ops, timeout, response-on-timeout-edge, ignored second pulse,
// and reset in WAIT with the clock stopped.
`timescale 1ns/1ps
module tb_jtag_dmi_intc;

  logic        clk = 1'b0;
  logic        clk_en = 1'b1;
  logic        dev_rst_n = 1'b0;
  logic        jreq_vld = 1'b0;
  logic [40:0] jreq_data = 41'h0;
  logic        jreq_rdy;
  logic        jresp_vld;
  logic [33:0] jresp_data;
  logic        jresp_rdy = 1'b1;
  logic        dmi_req_valid;
  logic        dmi_req_ready = 1'b0;
  logic [6:0]  dmi_req_addr;
  logic [31:0] dmi_req_data;
  logic [1:0]  dmi_req_op;
  logic        dmi_resp_valid = 1'b0;
  logic        dmi_resp_ready;
  logic [31:0] dmi_resp_data = 32'h0;
  logic [1:0]  dmi_resp_resp = 2'h0;

  int n_checks = 0;
  int n_pass   = 0;

  jtag_dmi_intc dut (
    .clk            (clk),
    .dev_rst_n      (dev_rst_n),
    .jreq_vld       (jreq_vld),
    .jreq_data      (jreq_data),
    .jreq_rdy       (jreq_rdy),
    .jresp_vld      (jresp_vld),
    .jresp_data     (jresp_data),
    .jresp_rdy      (jresp_rdy),
    .dmi_req_valid  (dmi_req_valid),
    .dmi_req_ready  (dmi_req_ready),
    .dmi_req_addr   (dmi_req_addr),
    .dmi_req_data   (dmi_req_data),
    .dmi_req_op     (dmi_req_op),
    .dmi_resp_valid (dmi_resp_valid),
    .dmi_resp_ready (dmi_resp_ready),
    .dmi_resp_data  (dmi_resp_data),
    .dmi_resp_resp  (dmi_resp_resp)
  );

  // Gated clock so reset can be exercised with no edges
  always #5 if (clk_en) clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp)
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    else
      n_pass++;
  endtask

  // One rising edge, then settle at the falling edge for sampling/driving
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_req(input logic [6:0] a, input logic [31:0] d, input logic [1:0] op);
    jreq_data = {a, d, op};
    jreq_vld  = 1'b1;
  endtask

  // Drop the request level and expect IDLE within three clocks
  task automatic finish_resp(input string tag);
    int n;
    n = 0;
    jreq_vld = 1'b0;
    while (!jreq_rdy && n < 8) begin
      tick();
      n++;
    end
    chk({tag, "_idle"}, {63'h0, (n <= 3) && jreq_rdy && !jresp_vld}, 64'h1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int req_seen;
    int resp_seen;

    // Reset state
    repeat (3) tick();
    chk("rst_flags", {60'h0, jreq_rdy, jresp_vld, dmi_req_valid, dmi_resp_ready}, 64'h8);
    chk("rst_jresp_data", {30'h0, jresp_data}, 64'h0);
    chk("rst_dmi_req", {23'h0, dmi_req_addr, dmi_req_data, dmi_req_op}, 64'h0);
    dev_rst_n = 1'b1;
    repeat (2) tick();
    chk("idle_rdy", {63'h0, jreq_rdy}, 64'h1);

    // Read with latency check
    dmi_req_ready = 1'b1;
    send_req(7'h11, 32'h0, 2'h1);
    tick(); chk("rd_lat_k",  {63'h0, dmi_req_valid}, 64'h0);
    tick(); chk("rd_lat_k1", {63'h0, dmi_req_valid}, 64'h0);
    tick(); chk("rd_lat_k2", {63'h0, dmi_req_valid}, 64'h1);
    chk("rd_addr_op", {55'h0, dmi_req_addr, dmi_req_op}, {55'h0, 7'h11, 2'h1});
    chk("rd_jreq_rdy", {63'h0, jreq_rdy}, 64'h0);
    tick(); chk("rd_wait", {62'h0, dmi_req_valid, dmi_resp_ready}, 64'h1);
    dmi_resp_valid = 1'b1; dmi_resp_data = 32'hCAFE0001; dmi_resp_resp = 2'h0;
    tick();
    dmi_resp_valid = 1'b0; dmi_resp_data = 32'h0;
    chk("rd_resp_flags", {62'h0, jresp_vld, dmi_resp_ready}, 64'h2);
    chk("rd_resp_data", {30'h0, jresp_data}, {30'h0, 32'hCAFE0001, 2'h0});
    tick();
    chk("rd_resp_hold", {29'h0, jresp_vld, jresp_data}, {29'h0, 1'b1, 32'hCAFE0001, 2'h0});
    finish_resp("rd");
    chk("rd_data_kept", {30'h0, jresp_data}, {30'h0, 32'hCAFE0001, 2'h0});

    // Write with 5 clocks of backpressure
    dmi_req_ready = 1'b0;
    send_req(7'h10, 32'h80000001, 2'h2);
    repeat (3) tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("wr_hold", {21'h0, dmi_req_valid, dmi_resp_ready, dmi_req_addr, dmi_req_data, dmi_req_op},
          {21'h0, 1'b1, 1'b0, 7'h10, 32'h80000001, 2'h2});
    end
    dmi_req_ready = 1'b1;
    tick();
    dmi_req_ready = 1'b0;
    chk("wr_wait", {62'h0, dmi_req_valid, dmi_resp_ready}, 64'h1);
    chk("wr_req_kept", {23'h0, dmi_req_addr, dmi_req_data, dmi_req_op}, {23'h0, 7'h10, 32'h80000001, 2'h2});
    dmi_resp_valid = 1'b1; dmi_resp_data = 32'h12345678; dmi_resp_resp = 2'h0;
    tick();
    dmi_resp_valid = 1'b0;
    chk("wr_resp", {29'h0, jresp_vld, jresp_data}, {29'h0, 1'b1, 32'h12345678, 2'h0});
    finish_resp("wr");

    // Reserved op 3: local failure response, no DMI request
    send_req(7'h06, 32'h0, 2'h3);
    repeat (3) tick();
    chk("op3_resp", {28'h0, jresp_vld, dmi_req_valid, jresp_data}, {28'h0, 1'b1, 1'b0, 34'h2});
    finish_resp("op3");

    // No-op: local zero response, payload still captured
    send_req(7'h05, 32'hFFFFFFFF, 2'h0);
    repeat (3) tick();
    chk("nop_resp", {28'h0, jresp_vld, dmi_req_valid, jresp_data}, {28'h0, 1'b1, 1'b0, 34'h0});
    chk("nop_capture", {32'h0, dmi_req_data}, {32'h0, 32'hFFFFFFFF});
    finish_resp("nop");

    // Timeout: no DMI response ever
    dmi_req_ready = 1'b1;
    send_req(7'h22, 32'h0, 2'h1);
    repeat (4) tick();
    chk("to_wait", {63'h0, dmi_resp_ready}, 64'h1);
    n = 0;
    while (!jresp_vld && n < 300) begin
      tick();
      n++;
    end
    chk("to_clks", 64'(n), 64'd255);
    chk("to_data", {30'h0, jresp_data}, 64'h2);
    finish_resp("to");

    // Response on the timeout edge wins
    send_req(7'h23, 32'h0, 2'h1);
    repeat (4) tick();
    repeat (254) tick();
    chk("pri_no_early", {63'h0, jresp_vld}, 64'h0);
    dmi_resp_valid = 1'b1; dmi_resp_data = 32'h0BADF00D; dmi_resp_resp = 2'h1;
    tick();
    dmi_resp_valid = 1'b0;
    chk("pri_resp", {29'h0, jresp_vld, jresp_data}, {29'h0, 1'b1, 32'h0BADF00D, 2'h1});
    finish_resp("pri");

    // Second jreq_vld pulse while in WAIT is ignored
    send_req(7'h24, 32'h0, 2'h1);
    repeat (4) tick();
    req_seen = 0;
    jreq_vld = 1'b0;
    repeat (3) begin tick(); req_seen += int'(dmi_req_valid); end
    jreq_vld = 1'b1;
    repeat (3) begin tick(); req_seen += int'(dmi_req_valid); end
    jreq_vld = 1'b0;
    repeat (3) begin tick(); req_seen += int'(dmi_req_valid); end
    dmi_resp_valid = 1'b1; dmi_resp_data = 32'h5555AAAA; dmi_resp_resp = 2'h0;
    tick();
    dmi_resp_valid = 1'b0;
    chk("dbl_resp", {29'h0, jresp_vld, jresp_data}, {29'h0, 1'b1, 32'h5555AAAA, 2'h0});
    finish_resp("dbl");
    resp_seen = 0;
    repeat (8) begin
      tick();
      req_seen  += int'(dmi_req_valid);
      resp_seen += int'(jresp_vld);
    end
    chk("dbl_no_req", 64'(req_seen), 64'd0);
    chk("dbl_no_resp", 64'(resp_seen), 64'd0);

    // Reset in WAIT with the clock stopped, request level still high
    send_req(7'h30, 32'hDEADBEEF, 2'h2);
    repeat (4) tick();
    chk("rw_wait", {63'h0, dmi_resp_ready}, 64'h1);
    clk_en = 1'b0;
    dev_rst_n = 1'b0;
    #20;
    chk("rw_rst_flags", {60'h0, jreq_rdy, jresp_vld, dmi_req_valid, dmi_resp_ready}, 64'h8);
    chk("rw_rst_jresp_data", {30'h0, jresp_data}, 64'h0);
    chk("rw_rst_dmi_req", {23'h0, dmi_req_addr, dmi_req_data, dmi_req_op}, 64'h0);
    dev_rst_n = 1'b1;
    #2;
    clk_en = 1'b1;
    tick(); chk("rr_lat_k",  {63'h0, dmi_req_valid}, 64'h0);
    tick(); chk("rr_lat_k1", {63'h0, dmi_req_valid}, 64'h0);
    tick();
    chk("rr_req", {22'h0, dmi_req_valid, dmi_req_addr, dmi_req_data, dmi_req_op},
        {22'h0, 1'b1, 7'h30, 32'hDEADBEEF, 2'h2});
    tick();
    dmi_resp_valid = 1'b1; dmi_resp_data = 32'h0; dmi_resp_resp = 2'h0;
    tick();
    dmi_resp_valid = 1'b0;
    chk("rr_resp", {29'h0, jresp_vld, jresp_data}, {29'h0, 1'b1, 34'h0});
    finish_resp("rr");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/jtag_dmi_intc.md
JTAG_DMI_INTC -- requirements
Module: jtag_dmi_intc

Interface
REQ-001 Parameters SHALL be: DMI_ADDR_WIDTH=7 (DMI address bits); DMI_DATA_WIDTH=32 (DMI data bits); DMI_OP_WIDTH=2 (op/response code bits); TIMEOUT_CYCLES=255 (max clocks waiting for DMI response).
REQ-002 The block SHALL have one clock and one reset; the reset is asynchronous and active-low.
REQ-003 Ports (name dir width meaning) SHALL be:
- clk  in  1  core clock
- dev_rst_n  in  1  asynchronous active-low reset
- jreq_vld  in  1  JTAG request valid level; asynchronous to clk
- jreq_data  in  41  {addr[40:34], data[33:2], op[1:0]}
- jreq_rdy  out  1  block idle, can accept a request
- jresp_vld  out  1  response valid level
- jresp_data  out  34  {data[33:2], resp[1:0]}
- jresp_rdy  in  1  JTAG side can take a response; asynchronous to clk
- dmi_req_valid  out  1  DMI request valid
- dmi_req_ready  in  1  DMI request ready
- dmi_req_addr  out  7  DMI address
- dmi_req_data  out  32  DMI write data
- dmi_req_op  out  2  DMI op: 1=read, 2=write
- dmi_resp_valid  in  1  DMI response valid
- dmi_resp_ready  out  1  DMI response ready
- dmi_resp_data  in  32  DMI read data
- dmi_resp_resp  in  2  DMI response code

Function
REQ-004 jreq_vld and jresp_rdy SHALL each pass through a 2-flop synchronizer; only the synchronized values are used.
REQ-005 A request event SHALL be a rising edge of synchronized jreq_vld, detected against a third registered copy.
REQ-006 The FSM SHALL have states IDLE, REQ, WAIT, RESP.
REQ-007 jreq_rdy SHALL be 1 only in IDLE. dmi_req_valid SHALL be 1 only in REQ. dmi_resp_ready SHALL be 1 only in WAIT. jresp_vld SHALL be 1 only in RESP.
REQ-008 IDLE, on a request event, SHALL capture jreq_data into the address, data and op registers on the same edge.
- If op is 1 or 2, the FSM SHALL go to REQ.
- If op is 0, it SHALL go to RESP with jresp_data={32'h0,2'h0}.
- If op is 3, it SHALL go to RESP with jresp_data={32'h0,2'h2}.
REQ-009 A request event in any state other than IDLE SHALL be ignored; no request is queued.
REQ-010 Latency: if clk edge k first samples jreq_vld=1, dmi_req_valid SHALL be 1 after edge k+2.
REQ-011 REQ SHALL hold dmi_req_addr, dmi_req_data and dmi_req_op stable. On an edge with dmi_req_ready=1, it SHALL go to WAIT. No timeout SHALL apply in REQ; valid is never withdrawn.
REQ-012 WAIT, on an edge with dmi_resp_valid=1, SHALL load jresp_data={dmi_resp_data,dmi_resp_resp} and go to RESP. jresp_vld SHALL be 1 after that same edge.
REQ-013 WAIT SHALL count clocks in an 8-bit counter, cleared on entry to WAIT.
- When the count reaches TIMEOUT_CYCLES with no response, the FSM SHALL load jresp_data={32'h0,2'h2} and go to RESP.
- A response on the timeout edge SHALL take priority over the timeout.
REQ-014 RESP SHALL hold jresp_data stable. It SHALL return to IDLE on the first edge where synchronized jreq_vld=0 and synchronized jresp_rdy=1.
REQ-015 jresp_data SHALL keep its last value after RESP is left, until the next response load.
REQ-016 dmi_req_* outputs SHALL keep the last captured values outside REQ.

Reset
REQ-017 While dev_rst_n=0, outputs SHALL be:
- jreq_rdy=1
- jresp_vld=0
- jresp_data=0
- dmi_req_valid=0
- dmi_req_addr=0
- dmi_req_data=0
- dmi_req_op=0
- dmi_resp_ready=0
REQ-018 While dev_rst_n=0, the synchronizers and edge register SHALL be 0, the counter 0 and the FSM in IDLE.
REQ-019 Reset asserted mid-transaction SHALL abort immediately to IDLE with no response generated.
REQ-020 If jreq_vld is already 1 at reset release, it SHALL be treated as one new request event.

Verification
REQ-021 Read: jreq_data={7'h11,32'h0,2'h1}, dmi_req_ready=1, response one cycle later with data 32'hCAFE0001 and resp 0. Required: dmi_req_valid after edge k+2 with addr 7'h11, op 1; jresp_vld=1; jresp_data={32'hCAFE0001,2'h0}.
REQ-022 Write with backpressure: op 2, addr 7'h10, data 32'h80000001, dmi_req_ready held 0 for 5 clocks. Required: dmi_req_valid and payload stable for all 5 clocks; WAIT entered on the ready edge.
REQ-023 Timeout: read with dmi_resp_valid never asserted. Required: jresp_vld=1 after exactly 255 clocks in WAIT; jresp_data={32'h0,2'h2}.
REQ-024 Second pulse on jreq_vld while in WAIT. Required: no second dmi_req_valid; only one response.
REQ-025 Handshake and reset: jreq_vld dropped during RESP with jresp_rdy=1. Required: IDLE within 3 clocks and jreq_rdy=1. Separately, dev_rst_n pulsed low in WAIT. Required: all outputs at reset values with no clock running.
